// File: rtl/instr_encoder.sv
// Packs decoded DLX fields into 32-bit words and writes them to consecutive imem addresses.
// One cycle from accepted beat to ImemWE; a stalled write holds InReady low until ImemReady.
module instr_encoder #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic              InValid,
    output logic              InReady,
    input  logic              InLast,
    input  logic [5:0]        InOp,
    input  logic [5:0]        InFunct,
    input  logic [4:0]        InRs,
    input  logic [4:0]        InRt,
    input  logic [4:0]        InRd,
    input  logic [15:0]       InImm,
    input  logic [25:0]       InTarget,
    output logic              ImemWE,
    input  logic              ImemReady,
    output logic [ADDR_W-1:0] ImemAddr,
    output logic [31:0]       ImemWD,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  WordCount,
    output logic [CNT_W-1:0]  ErrCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wd;
    logic [CNT_W-1:0]  r_words;
    logic [CNT_W-1:0]  r_errs;
    logic              r_last_seen;

    logic              w_supported;
    logic [31:0]       w_word;
    logic              w_accept;
    logic              w_wr_done;

    always_comb begin
        w_supported = 1'b0;
        w_word      = {InOp, InRs, InRt, InImm};
        if (InOp == 6'h00) begin
            w_word = {6'h00, InRs, InRt, InRd, 5'h00, InFunct};
            case (InFunct)
                6'h04, 6'h06, 6'h07, 6'h20, 6'h22, 6'h24,
                6'h25, 6'h26, 6'h28, 6'h29, 6'h2a, 6'h2c: w_supported = 1'b1;
                default: w_supported = 1'b0;
            endcase
        end else begin
            case (InOp)
                6'h02, 6'h03: begin
                    w_supported = 1'b1;
                    w_word      = {InOp, InTarget};
                end
                6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
                6'h12, 6'h13, 6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1a,
                6'h1c, 6'h23, 6'h2b: w_supported = 1'b1;
                default: w_supported = 1'b0;
            endcase
        end
    end

    assign InReady   = (r_state == S_ACTIVE) && (!r_we || ImemReady);
    assign w_accept  = InValid && InReady;
    assign w_wr_done = r_we && ImemReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wd        <= '0;
            r_words     <= '0;
            r_errs      <= '0;
            r_last_seen <= 1'b0;
        end else begin
            // Completion first so a same-cycle acceptance can reload the register.
            if (w_wr_done) begin
                r_we   <= 1'b0;
                r_addr <= r_addr + ADDR_W'(4);
                if (r_words != CNT_MAX) r_words <= r_words + CNT_W'(1);
            end
            if (w_accept) begin
                if (w_supported) begin
                    r_we <= 1'b1;
                    r_wd <= w_word;
                end else if (r_errs != CNT_MAX) begin
                    r_errs <= r_errs + CNT_W'(1);
                end
                if (InLast) r_last_seen <= 1'b1;
            end
            case (r_state)
                S_IDLE: if (Start) begin
                    r_state     <= S_ACTIVE;
                    r_addr      <= {BaseAddr[ADDR_W-1:2], 2'b00};
                    r_words     <= '0;
                    r_errs      <= '0;
                    r_last_seen <= 1'b0;
                end
                S_ACTIVE: if (w_accept && InLast) r_state <= S_FLUSH;
                S_FLUSH: if (r_last_seen && !r_we) begin
                    r_state     <= S_DONE;
                    r_last_seen <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ImemWE    = r_we;
    assign ImemAddr  = r_addr;
    assign ImemWD    = r_wd;
    assign WordCount = r_words;
    assign ErrCount  = r_errs;
    assign Busy      = (r_state != S_IDLE);
    assign Done      = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized programs against a queue-based model.
module tb_instr_encoder;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [31:0] BaseAddr;
    logic        InValid;
    logic        InReady;
    logic        InLast;
    logic [5:0]  InOp;
    logic [5:0]  InFunct;
    logic [4:0]  InRs;
    logic [4:0]  InRt;
    logic [4:0]  InRd;
    logic [15:0] InImm;
    logic [25:0] InTarget;
    logic        ImemWE;
    logic        ImemReady;
    logic [31:0] ImemAddr;
    logic [31:0] ImemWD;
    logic        Busy;
    logic        Done;
    logic [15:0] WordCount;
    logic [15:0] ErrCount;

    instr_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Start(Start), .BaseAddr(BaseAddr),
        .InValid(InValid), .InReady(InReady), .InLast(InLast),
        .InOp(InOp), .InFunct(InFunct), .InRs(InRs), .InRt(InRt), .InRd(InRd),
        .InImm(InImm), .InTarget(InTarget),
        .ImemWE(ImemWE), .ImemReady(ImemReady), .ImemAddr(ImemAddr), .ImemWD(ImemWD),
        .Busy(Busy), .Done(Done), .WordCount(WordCount), .ErrCount(ErrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          words_base = 0;
    int          m_err = 0;
    int          acc_cyc = 0;
    logic [31:0] m_addr;
    logic        last_acc;
    logic        bp_rand = 1'b0;
    logic        stall_prev = 1'b0;
    logic [31:0] st_a, st_d;
    wr_t         exp_q[$];
    wr_t         log_q[$];

    logic [5:0] ops_ok[21] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0c, 6'h0d,
                               6'h0e, 6'h0f, 6'h12, 6'h13, 6'h14, 6'h16, 6'h17, 6'h18,
                               6'h19, 6'h1a, 6'h1c, 6'h23, 6'h2b};
    logic [5:0] fn_ok[12]  = '{6'h04, 6'h06, 6'h07, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                               6'h28, 6'h29, 6'h2a, 6'h2c};

    function automatic bit ref_ok(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {fn_ok};
        return op inside {ops_ok};
    endfunction

    function automatic logic [31:0] ref_enc(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [4:0] rs, input logic [4:0] rt,
                                            input logic [4:0] rd, input logic [15:0] imm,
                                            input logic [25:0] tgt);
        if (op == 6'h00) return {6'h00, rs, rt, rd, 5'h00, fn};
        if (op == 6'h02 || op == 6'h03) return {op, tgt};
        return {op, rs, rt, imm};
    endfunction

    // One clock cycle: scoreboard the write channel just before the edge, then advance.
    task automatic step;
        wr_t e;
        if (bp_rand) ImemReady = ($urandom_range(0, 3) != 0);
        #1;
        if (reset === 1'b0) begin
            if (stall_prev) begin
                tests++;
                if (ImemWE !== 1'b1 || ImemAddr !== st_a || ImemWD !== st_d) begin
                    fails++;
                    $display("FAIL stall_hold: we=%b addr=%h wd=%h, required we=1 addr=%h wd=%h",
                             ImemWE, ImemAddr, ImemWD, st_a, st_d);
                end
            end
            if (ImemWE === 1'b1 && ImemReady === 1'b1) begin
                tests++;
                log_q.push_back('{ImemAddr, ImemWD});
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr=%h wd=%h, required no write", ImemAddr, ImemWD);
                end else begin
                    e = exp_q.pop_front();
                    if (ImemAddr !== e.a || ImemWD !== e.d) begin
                        fails++;
                        $display("FAIL write: addr=%h wd=%h, required addr=%h wd=%h",
                                 ImemAddr, ImemWD, e.a, e.d);
                    end
                end
            end
            if (Done === 1'b1) done_cnt++;
            stall_prev = (ImemWE === 1'b1) && (ImemReady !== 1'b1);
            st_a = ImemAddr;
            st_d = ImemWD;
        end else begin
            stall_prev = 1'b0;
        end
        last_acc = (InValid === 1'b1) && (InReady === 1'b1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic last);
        bit acc = 0;
        InOp = op; InFunct = fn; InRs = rs; InRt = rt; InRd = rd;
        InImm = imm; InTarget = tgt; InLast = last; InValid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            step();
            if (last_acc) begin
                acc = 1;
                break;
            end
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        acc_cyc = cyc;
        tests++;
        if (!acc) begin
            fails++;
            $display("FAIL send_timeout: accepted=0, required accepted=1 within 200 cycles");
        end else if (ref_ok(op, fn)) begin
            exp_q.push_back('{m_addr, ref_enc(op, fn, rs, rt, rd, imm, tgt)});
            m_addr = m_addr + 32'd4;
        end else begin
            m_err++;
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        Start      = 1'b1;
        BaseAddr   = base;
        m_addr     = base & ~32'd3;
        m_err      = 0;
        words_base = log_q.size();
        done_base  = done_cnt;
        exp_q.delete();
        step();
        Start = 1'b0;
    endtask

    task automatic finish_prog;
        bit got = 0;
        for (int n = 0; n < 300; n++) begin
            step();
            if (done_cnt != done_base) begin
                got = 1;
                break;
            end
        end
        repeat (3) step();
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL done_timeout: done seen=0, required 1 within 300 cycles");
        end
        tests++;
        if (done_cnt - done_base != 1) begin
            fails++;
            $display("FAIL done_pulses: got %0d, required 1", done_cnt - done_base);
        end
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_done: got %b, required 0", Busy);
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL missing_writes: got %0d pending, required 0", exp_q.size());
        end
        tests++;
        if (WordCount !== 16'(log_q.size() - words_base)) begin
            fails++;
            $display("FAIL word_count: got %0d, required %0d", WordCount, log_q.size() - words_base);
        end
        tests++;
        if (ErrCount !== 16'(m_err)) begin
            fails++;
            $display("FAIL err_count: got %0d, required %0d", ErrCount, m_err);
        end
    endtask

    task automatic test_reset;
        InValid = 1'b1;
        #1;
        tests++;
        if ({ImemWE, ImemAddr, ImemWD, Busy, Done, WordCount, ErrCount} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: we=%b addr=%h wd=%h busy=%b done=%b wc=%0d ec=%0d, required all 0",
                     ImemWE, ImemAddr, ImemWD, Busy, Done, WordCount, ErrCount);
        end
        tests++;
        if (InReady !== 1'b0) begin
            fails++;
            $display("FAIL reset_inready: got %b, required 0", InReady);
        end
        InValid = 1'b0;
    endtask

    task automatic test_add;
        ImemReady = 1'b1;
        do_start(32'h100);
        send(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        tests++;
        if (ImemWE !== 1'b1 || ImemAddr !== 32'h100 || ImemWD !== 32'h00221820) begin
            fails++;
            $display("FAIL add_word: we=%b addr=%h wd=%h, required we=1 addr=00000100 wd=00221820",
                     ImemWE, ImemAddr, ImemWD);
        end
        finish_prog();
    endtask

    task automatic test_program;
        do_start(32'h100);
        send(6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0005, 26'h0, 1'b0);
        Start    = 1'b1;
        BaseAddr = 32'h500;
        step();
        Start    = 1'b0;
        send(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1);
        finish_prog();
        tests++;
        if (log_q.size() < words_base + 2 ||
            log_q[words_base].a !== 32'h100 || log_q[words_base].d !== 32'h20220005 ||
            log_q[words_base+1].a !== 32'h104 || log_q[words_base+1].d !== 32'h08000010) begin
            fails++;
            $display("FAIL program_words: writes=%0d, required 100:20220005 then 104:08000010",
                     log_q.size() - words_base);
        end
        tests++;
        if (WordCount !== 16'd2) begin
            fails++;
            $display("FAIL program_count: got %0d, required 2", WordCount);
        end
    endtask

    task automatic test_errors;
        do_start(32'h200);
        send(6'h3f, 6'h00, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0, 1'b0);
        send(6'h00, 6'h3f, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        send(6'h2b, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0, 1'b1);
        finish_prog();
        tests++;
        if (ErrCount !== 16'd2 || WordCount !== 16'd1) begin
            fails++;
            $display("FAIL error_counts: ec=%0d wc=%0d, required ec=2 wc=1", ErrCount, WordCount);
        end
        tests++;
        if (log_q.size() < words_base + 1 ||
            log_q[words_base].a !== 32'h200 || log_q[words_base].d !== 32'hAC220010) begin
            fails++;
            $display("FAIL error_sw: writes=%0d, required 200:ac220010", log_q.size() - words_base);
        end
    endtask

    task automatic test_backpressure;
        int cb, cc;
        do_start(32'h300);
        ImemReady = 1'b0;
        send(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        InOp = 6'h08; InRs = 5'd4; InRt = 5'd5; InImm = 16'h7; InLast = 1'b0; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (last_acc || InReady !== 1'b0 || ImemAddr !== 32'h300 || ImemWD !== 32'h00221820) begin
                fails++;
                $display("FAIL bp_hold: acc=%b inready=%b addr=%h wd=%h, required acc=0 inready=0 addr=00000300 wd=00221820",
                         last_acc, InReady, ImemAddr, ImemWD);
            end
        end
        InValid   = 1'b0;
        ImemReady = 1'b1;
        send(6'h08, 6'h00, 5'd4, 5'd5, 5'd0, 16'h7, 26'h0, 1'b0);
        cb = acc_cyc;
        send(6'h0d, 6'h00, 5'd6, 5'd7, 5'd0, 16'hbeef, 26'h0, 1'b0);
        cc = acc_cyc;
        send(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3ffffff, 1'b1);
        tests++;
        if (cc - cb != 1 || acc_cyc - cc != 1) begin
            fails++;
            $display("FAIL bp_throughput: gaps=%0d,%0d cycles, required 1,1", cc - cb, acc_cyc - cc);
        end
        finish_prog();
    endtask

    task automatic test_wrap;
        do_start(32'hFFFFFFFC);
        send(6'h23, 6'h00, 5'd9, 5'd10, 5'd0, 16'hfffc, 26'h0, 1'b0);
        send(6'h00, 6'h2a, 5'd11, 5'd12, 5'd13, 16'h0, 26'h0, 1'b1);
        finish_prog();
        tests++;
        if (log_q.size() < words_base + 2 ||
            log_q[words_base].a !== 32'hFFFFFFFC || log_q[words_base+1].a !== 32'h0) begin
            fails++;
            $display("FAIL wrap_addr: writes=%0d, required fffffffc then 00000000", log_q.size() - words_base);
        end
    endtask

    task automatic test_reset_mid;
        int nacc = 0;
        int nlog;
        do_start(32'h400);
        ImemReady = 1'b0;
        send(6'h00, 6'h22, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        reset = 1'b1;
        #2;
        tests++;
        if ({ImemWE, ImemAddr, ImemWD, InReady, Busy, Done, WordCount, ErrCount} !== '0) begin
            fails++;
            $display("FAIL reset_mid: we=%b addr=%h wd=%h inready=%b busy=%b, required all 0",
                     ImemWE, ImemAddr, ImemWD, InReady, Busy);
        end
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        ImemReady = 1'b1;
        nlog = log_q.size();
        InOp = 6'h08; InLast = 1'b1; InValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_acc) nacc++;
        end
        InValid = 1'b0;
        InLast  = 1'b0;
        tests++;
        if (nacc != 0 || log_q.size() != nlog || Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_need_start: accepted=%0d writes=%0d busy=%b, required 0 0 0",
                     nacc, log_q.size() - nlog, Busy);
        end
        do_start(32'h400);
        send(6'h0f, 6'h00, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0, 1'b1);
        finish_prog();
    endtask

    task automatic test_random;
        logic [5:0] op, fn;
        int n, r;
        bp_rand = 1'b1;
        for (int p = 0; p < 6; p++) begin
            do_start($urandom);
            n = $urandom_range(3, 12);
            for (int k = 0; k < n; k++) begin
                r  = $urandom_range(0, 9);
                op = ops_ok[$urandom_range(0, 20)];
                fn = 6'($urandom);
                if (r < 3) begin
                    op = 6'h00;
                    if (r < 2) fn = fn_ok[$urandom_range(0, 11)];
                end else if (r == 9) begin
                    op = 6'($urandom);
                end
                send(op, fn, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                     26'($urandom), k == n - 1);
            end
            finish_prog();
        end
        bp_rand   = 1'b0;
        ImemReady = 1'b1;
    endtask

    initial begin
        reset = 1'b1; Start = 1'b0; BaseAddr = '0; InValid = 1'b0; InLast = 1'b0;
        InOp = '0; InFunct = '0; InRs = '0; InRt = '0; InRd = '0; InImm = '0; InTarget = '0;
        ImemReady = 1'b1;
        m_addr = '0; last_acc = 1'b0; st_a = '0; st_d = '0;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_add();
        test_program();
        test_errors();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
